// File: rtl/experiment_scenario_fsm.sv
// Scenario engine for the EXPERIMENT / EXPERIMENT_PHASE sequences of scenario_multiplexer.
// Optional wire-continuity abort is enabled by defining WIRE_CHECK_EN.
module experiment_scenario_fsm #(
    parameter int unsigned CNT_W     = 32,
    parameter bit          SYNC_EDGE = 1'b1
) (
    input  logic             clock_reg_input,
    input  logic             reset_reg_input,
    input  logic             phase_mode_reg_input,
    input  logic             start_reg_input,
    input  logic             fg_reg_input,
    input  logic             phase_reg_input,
    input  logic             wire_reg_input,
    input  logic             detector_ready_reg_input,
    input  logic [CNT_W-1:0] fg_open_delay_reg_input,
    input  logic [CNT_W-1:0] detectr_ready_timeout_reg_input,
    input  logic [CNT_W-1:0] phase_shift_reg_input,
    input  logic [CNT_W-1:0] detonate_len_reg_input,
    input  logic [CNT_W-1:0] trigger_len_reg_input,
    output logic             detonation_signal_reg_output,
    output logic             trigger_reg_output,
    output logic [7:0]       scenario_state_reg_output,
    output logic [CNT_W-1:0] counter_reg_output
);

    typedef enum logic [7:0] {
        ST_IDLE        = 8'h00,
        ST_WAIT_READY  = 8'h01,
        ST_FG_WAIT     = 8'h02,
        ST_FG_DELAY    = 8'h03,
        ST_PHASE_WAIT  = 8'h04,
        ST_PHASE_SHIFT = 8'h05,
        ST_DETONATE    = 8'h06,
        ST_TRIGGER     = 8'h07,
        ST_DONE        = 8'h08,
        ST_ERR_TIMEOUT = 8'hE1,
        ST_ERR_WIRE    = 8'hE2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             start_prev_q, phase_prev_q;
    logic             phase_mode_q;
    logic [CNT_W-1:0] fg_delay_q, timeout_q, shift_q, det_len_q, trig_len_q;
    logic             latch_c;
    logic             start_rise_c, start_go_c, phase_go_c, wire_fault_c;

    // Index of the final cycle of a timed state; a zero length still takes one cycle.
    function automatic logic [CNT_W-1:0] last_cycle(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    assign start_rise_c = start_reg_input & ~start_prev_q;
    assign start_go_c   = SYNC_EDGE ? start_rise_c : start_reg_input;
    assign phase_go_c   = SYNC_EDGE ? (phase_reg_input & ~phase_prev_q) : phase_reg_input;

`ifdef WIRE_CHECK_EN
    assign wire_fault_c = ~wire_reg_input;
`else
    logic unused_wire;
    assign unused_wire  = wire_reg_input;
    assign wire_fault_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clock_reg_input) begin
        if (!reset_reg_input) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_go_c) begin
                    state_d = ST_WAIT_READY;
                    latch_c = 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (wire_fault_c) begin
                    state_d = ST_ERR_WIRE;
                end else if (detector_ready_reg_input) begin
                    state_d = ST_FG_WAIT;
                end else if ((timeout_q != '0) && (cnt_q == timeout_q - CNT_W'(1))) begin
                    state_d = ST_ERR_TIMEOUT;
                end
            end
            ST_FG_WAIT: begin
                if (wire_fault_c) begin
                    state_d = ST_ERR_WIRE;
                end else if (fg_reg_input) begin
                    state_d = ST_FG_DELAY;
                end
            end
            ST_FG_DELAY: begin
                if (wire_fault_c) begin
                    state_d = ST_ERR_WIRE;
                end else if (cnt_q >= last_cycle(fg_delay_q)) begin
                    state_d = phase_mode_q ? ST_PHASE_WAIT : ST_DETONATE;
                end
            end
            ST_PHASE_WAIT: begin
                if (wire_fault_c) begin
                    state_d = ST_ERR_WIRE;
                end else if (phase_go_c) begin
                    state_d = ST_PHASE_SHIFT;
                end
            end
            ST_PHASE_SHIFT: begin
                if (wire_fault_c) begin
                    state_d = ST_ERR_WIRE;
                end else if (cnt_q >= last_cycle(shift_q)) begin
                    state_d = ST_DETONATE;
                end
            end
            ST_DETONATE: begin
                if (cnt_q >= last_cycle(det_len_q)) begin
                    state_d = ST_TRIGGER;
                end
            end
            ST_TRIGGER: begin
                if (cnt_q >= last_cycle(trig_len_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_reg_input) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR_TIMEOUT, ST_ERR_WIRE: begin
                // Only a genuine low-to-high start re-arms, even in level mode.
                if (start_rise_c) begin
                    state_d = ST_WAIT_READY;
                    latch_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter, edge history, parameter latches and outputs decoded from next state
    always_ff @(posedge clock_reg_input) begin
        if (!reset_reg_input) begin
            cnt_q                        <= '0;
            start_prev_q                 <= 1'b0;
            phase_prev_q                 <= 1'b0;
            phase_mode_q                 <= 1'b0;
            fg_delay_q                   <= '0;
            timeout_q                    <= '0;
            shift_q                      <= '0;
            det_len_q                    <= '0;
            trig_len_q                   <= '0;
            detonation_signal_reg_output <= 1'b0;
            trigger_reg_output           <= 1'b0;
        end else begin
            start_prev_q <= start_reg_input;
            phase_prev_q <= phase_reg_input;
            if ((state_d != state_q) || (state_d == ST_IDLE)) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (latch_c) begin
                phase_mode_q <= phase_mode_reg_input;
                fg_delay_q   <= fg_open_delay_reg_input;
                timeout_q    <= detectr_ready_timeout_reg_input;
                shift_q      <= phase_shift_reg_input;
                det_len_q    <= detonate_len_reg_input;
                trig_len_q   <= trigger_len_reg_input;
            end
            detonation_signal_reg_output <= (state_d == ST_DETONATE);
            trigger_reg_output           <= (state_d == ST_TRIGGER);
        end
    end

    assign scenario_state_reg_output = state_q;
    assign counter_reg_output        = cnt_q;

endmodule

// File: tb/tb_experiment_scenario_fsm.sv
// Directed self-checking bench for experiment_scenario_fsm; WIRE_CHECK_EN selects wire-abort expectations.
module tb_experiment_scenario_fsm;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode, start, fg, phase, wire_ok, ready;
    logic [CNT_W-1:0] fg_delay, timeout, shift, det_len, trig_len;
    logic             det, trig;
    logic [7:0]       st;
    logic [CNT_W-1:0] cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    experiment_scenario_fsm dut (
        .clock_reg_input                 (clk),
        .reset_reg_input                 (rst_n),
        .phase_mode_reg_input            (mode),
        .start_reg_input                 (start),
        .fg_reg_input                    (fg),
        .phase_reg_input                 (phase),
        .wire_reg_input                  (wire_ok),
        .detector_ready_reg_input        (ready),
        .fg_open_delay_reg_input         (fg_delay),
        .detectr_ready_timeout_reg_input (timeout),
        .phase_shift_reg_input           (shift),
        .detonate_len_reg_input          (det_len),
        .trigger_len_reg_input           (trig_len),
        .detonation_signal_reg_output    (det),
        .trigger_reg_output              (trig),
        .scenario_state_reg_output       (st),
        .counter_reg_output              (cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; phase = 1'b0; fg = 1'b0; ready = 1'b0; wire_ok = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_params(input logic m, input int d, input int t, input int s,
                              input int dl, input int tl);
        mode = m; fg_delay = d; timeout = t; shift = s; det_len = dl; trig_len = tl;
    endtask

    task automatic test_reset();
        apply_reset();
        vec_cnt++;
        if ({st, cnt, det, trig} !== {8'h00, 32'd0, 2'b00}) begin
            err_cnt++;
            $display("FAIL reset_init: st=%h cnt=%0d det=%b trig=%b, want 00/0/0/0", st, cnt, det, trig);
        end
        set_params(1'b0, 0, 0, 0, 50, 50);
        ready = 1'b1; fg = 1'b1; start = 1'b1;
        tick(); tick(); tick(); tick();
        vec_cnt++;
        if ({st, det, trig} !== {8'h06, 2'b10}) begin
            err_cnt++;
            $display("FAIL reset_pre: st=%h det=%b trig=%b, want 06/1/0", st, det, trig);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++;
            if ({st, cnt, det, trig} !== {8'h00, 32'd0, 2'b00}) begin
                err_cnt++;
                $display("FAIL reset_mid[%0d]: st=%h cnt=%0d det=%b trig=%b, want 00/0/0/0", i, st, cnt, det, trig);
            end
        end
        start = 1'b0; rst_n = 1'b1;
        tick();
        vec_cnt++;
        if ({st, cnt, det, trig} !== {8'h00, 32'd0, 2'b00}) begin
            err_cnt++;
            $display("FAIL reset_post: st=%h cnt=%0d, want 00/0", st, cnt);
        end
    endtask

    task automatic test_experiment();
        apply_reset();
        set_params(1'b0, 10, 0, 0, 4, 3);
        ready = 1'b1; start = 1'b1;
        tick();
        vec_cnt++;
        if ({st, cnt} !== {8'h01, 32'd0}) begin
            err_cnt++;
            $display("FAIL exp_start: st=%h cnt=%0d, want 01/0", st, cnt);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            vec_cnt++;
            if ({st, cnt, det, trig} !== {8'h02, 32'(i), 2'b00}) begin
                err_cnt++;
                $display("FAIL exp_fgwait[%0d]: st=%h cnt=%0d, want 02/%0d", i, st, cnt, i);
            end
            if (i == 4) fg = 1'b1;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            vec_cnt++;
            if ({st, cnt, det, trig} !== {8'h03, 32'(i), 2'b00}) begin
                err_cnt++;
                $display("FAIL exp_delay[%0d]: st=%h cnt=%0d det=%b, want 03/%0d/0", i, st, cnt, det, i);
            end
            if (i == 1) fg_delay = 2;
            if (i == 3) start = 1'b0;
            if (i == 4) start = 1'b1;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if ({st, cnt, det, trig} !== {8'h06, 32'(i), 2'b10}) begin
                err_cnt++;
                $display("FAIL exp_det[%0d]: st=%h cnt=%0d det=%b trig=%b, want 06/%0d/1/0", i, st, cnt, det, trig, i);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if ({st, cnt, det, trig} !== {8'h07, 32'(i), 2'b01}) begin
                err_cnt++;
                $display("FAIL exp_trig[%0d]: st=%h cnt=%0d det=%b trig=%b, want 07/%0d/0/1", i, st, cnt, det, trig, i);
            end
            tick();
        end
        vec_cnt++;
        if ({st, cnt, det, trig} !== {8'h08, 32'd0, 2'b00}) begin
            err_cnt++;
            $display("FAIL exp_done: st=%h cnt=%0d det=%b trig=%b, want 08/0/0/0", st, cnt, det, trig);
        end
        start = 1'b0;
        tick();
        vec_cnt++;
        if (st !== 8'h00) begin
            err_cnt++;
            $display("FAIL exp_idle: st=%h, want 00", st);
        end
        start = 1'b1;
        tick();
        vec_cnt++;
        if ({st, cnt} !== {8'h01, 32'd0}) begin
            err_cnt++;
            $display("FAIL back_to_back: st=%h cnt=%0d, want 01/0", st, cnt);
        end
    endtask

    task automatic test_phase();
        apply_reset();
        set_params(1'b1, 3, 0, 7, 2, 1);
        ready = 1'b1; start = 1'b1;
        tick(); tick();
        fg = 1'b1;
        tick();
        phase = 1'b1; shift = 1;
        tick();
        phase = 1'b0;
        tick();
        vec_cnt++;
        if ({st, cnt} !== {8'h03, 32'd2}) begin
            err_cnt++;
            $display("FAIL ph_delay: st=%h cnt=%0d, want 03/2", st, cnt);
        end
        tick(); tick();
        vec_cnt++;
        if ({st, cnt} !== {8'h04, 32'd1}) begin
            err_cnt++;
            $display("FAIL ph_early_ignored: st=%h cnt=%0d, want 04/1", st, cnt);
        end
        phase = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            vec_cnt++;
            if ({st, cnt, det, trig} !== {8'h05, 32'(i), 2'b00}) begin
                err_cnt++;
                $display("FAIL ph_shift[%0d]: st=%h cnt=%0d det=%b, want 05/%0d/0", i, st, cnt, det, i);
            end
            tick();
        end
        vec_cnt++;
        if ({st, cnt, det, trig} !== {8'h06, 32'd0, 2'b10}) begin
            err_cnt++;
            $display("FAIL ph_det: st=%h cnt=%0d det=%b, want 06/0/1", st, cnt, det);
        end
        tick(); tick();
        vec_cnt++;
        if ({st, det, trig} !== {8'h07, 2'b01}) begin
            err_cnt++;
            $display("FAIL ph_trig: st=%h det=%b trig=%b, want 07/0/1", st, det, trig);
        end
        tick();
        vec_cnt++;
        if ({st, det, trig} !== {8'h08, 2'b00}) begin
            err_cnt++;
            $display("FAIL ph_done: st=%h det=%b trig=%b, want 08/0/0", st, det, trig);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        set_params(1'b0, 1, 20, 0, 1, 1);
        ready = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            vec_cnt++;
            if ({st, cnt} !== {8'h01, 32'(i)}) begin
                err_cnt++;
                $display("FAIL to_wait[%0d]: st=%h cnt=%0d, want 01/%0d", i, st, cnt, i);
            end
            tick();
        end
        vec_cnt++;
        if ({st, cnt, det, trig} !== {8'hE1, 32'd0, 2'b00}) begin
            err_cnt++;
            $display("FAIL to_err: st=%h cnt=%0d, want E1/0", st, cnt);
        end
        tick();
        start = 1'b0;
        tick();
        vec_cnt++;
        if ({st, cnt} !== {8'hE1, 32'd2}) begin
            err_cnt++;
            $display("FAIL to_sticky: st=%h cnt=%0d, want E1/2", st, cnt);
        end
        start = 1'b1;
        tick();
        vec_cnt++;
        if ({st, cnt} !== {8'h01, 32'd0}) begin
            err_cnt++;
            $display("FAIL to_rearm: st=%h cnt=%0d, want 01/0", st, cnt);
        end
    endtask

    task automatic test_zero_params();
        logic [7:0] exp_st [8];
        exp_st = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        apply_reset();
        set_params(1'b1, 0, 1, 0, 0, 0);
        ready = 1'b1; fg = 1'b1; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) phase = 1'b1;
            tick();
            vec_cnt++;
            if ({st, cnt, det, trig} !== {exp_st[i], 32'd0, exp_st[i] == 8'h06, exp_st[i] == 8'h07}) begin
                err_cnt++;
                $display("FAIL zero[%0d]: st=%h cnt=%0d det=%b trig=%b, want %h/0", i, st, cnt, det, trig, exp_st[i]);
            end
        end
        tick();
        vec_cnt++;
        if ({st, cnt} !== {8'h08, 32'd1}) begin
            err_cnt++;
            $display("FAIL zero_hold: st=%h cnt=%0d, want 08/1", st, cnt);
        end
    endtask

    task automatic test_wire();
        logic det_seen;
        logic overlap;
        det_seen = 1'b0; overlap = 1'b0;
        apply_reset();
        set_params(1'b0, 2, 0, 0, 1, 1);
        ready = 1'b1; start = 1'b1;
        tick(); tick();
        wire_ok = 1'b0;
        tick();
        vec_cnt++;
`ifdef WIRE_CHECK_EN
        if (st !== 8'hE2) begin
            err_cnt++;
            $display("FAIL wire_abort: st=%h, want E2", st);
        end
`else
        if (st !== 8'h02) begin
            err_cnt++;
            $display("FAIL wire_ignored: st=%h, want 02", st);
        end
`endif
        fg = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (det) det_seen = 1'b1;
            if (det && trig) overlap = 1'b1;
        end
        vec_cnt++;
`ifdef WIRE_CHECK_EN
        if ({st, det_seen} !== {8'hE2, 1'b0}) begin
            err_cnt++;
            $display("FAIL wire_end: st=%h det_seen=%b, want E2/0", st, det_seen);
        end
`else
        if ({st, det_seen} !== {8'h08, 1'b1}) begin
            err_cnt++;
            $display("FAIL wire_end: st=%h det_seen=%b, want 08/1", st, det_seen);
        end
`endif
        vec_cnt++;
        if (overlap !== 1'b0) begin
            err_cnt++;
            $display("FAIL wire_overlap: det&trig=%b, want 0", overlap);
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; start = 1'b0; fg = 1'b0; phase = 1'b0;
        wire_ok = 1'b1; ready = 1'b0;
        set_params(1'b0, 0, 0, 0, 0, 0);
        test_reset();
        test_experiment();
        test_phase();
        test_timeout();
        test_zero_params();
        test_wire();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
